carfield_rst_seq: RTL and testbench
===================================

# carfield_rst_seq

Parametrised reset-domain sequencer that owns the per-domain active-low resets of the Carfield islands. Domains include peripherals, safety island, security island, integer cluster, FP cluster and L2. Before asserting a domain reset it isolates the domain's AXI ports and waits for drain, then holds reset for a fixed count and de-isolates. After power-on it releases domains staggered by index. It sits between the Carfield register file (software requests) and the island wrappers, alongside Cheshire.

## Interface
Parameters:
- NumDomains, 6: number of reset domains; index order follows the package reset-domain enum (0 = peripherals).
- HoldCycles, 16: cycles a domain reset stays asserted; must be >= 1.
- TimeoutCycles, 256: isolation-ack wait limit; used only with the timeout feature.

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_ni  in  1  reset; synchronous, active-low.
- rst_req_i  in  NumDomains  per-domain reset request; level, sampled every edge.
- iso_ack_i  in  NumDomains  domain isolation complete (outstanding AXI transactions drained).
- timeout_clr_i  in  1  clears all sticky timeout flags.
- iso_o  out  NumDomains  isolate domain AXI ports.
- dom_rst_no  out  NumDomains  domain reset, active-low.
- busy_o  out  NumDomains  domain sequencer not IDLE.
- timeout_o  out  NumDomains  sticky isolation-timeout flag.

## Operation
- One independent FSM per domain. States: IDLE, ISOLATE, HOLD, UNISO.
- Outputs are Moore-decoded from registered state:
  - IDLE: iso=0, rst_n=1.
  - ISOLATE: iso=1, rst_n=1.
  - HOLD: iso=1, rst_n=0.
  - UNISO: iso=1, rst_n=1.
  - busy = (state != IDLE).
- Transitions:
  - IDLE -> ISOLATE when rst_req_i[i]=1.
  - ISOLATE -> HOLD when iso_ack_i[i]=1; counter loads HoldCycles-1.
  - HOLD: counter decrements each cycle; HOLD -> UNISO on the cycle the counter is 0.
  - UNISO -> IDLE unconditionally.
- Requests seen in any state other than IDLE are ignored (not queued). A request still high on return to IDLE starts a new sequence.
- iso_ack_i is ignored outside ISOLATE.
- Simultaneous requests on several domains run in parallel, with no arbitration.
- Counter width is $clog2(HoldCycles+NumDomains)+1, unsigned. It never wraps: the load value is bounded and decrement stops at 0.

## Timing
- While rst_ni=0 (synchronous), every domain is in HOLD:
  - dom_rst_no=0, iso_o=1, busy_o=1, timeout_o=0.
  - Counter[i] = HoldCycles-1+i.
- Power-on release: domain i's dom_rst_no rises HoldCycles+i cycles after the first edge with rst_ni=1. iso_o[i] falls 1 cycle later. Domains therefore release strictly in index order, one cycle apart.
- Request latency:
  - req high at edge t -> iso_o high from t+1.
  - ack high at edge a -> dom_rst_no low for exactly HoldCycles cycles, starting a+1.
  - UNISO then lasts 1 cycle, so dom_rst_no is high one cycle before iso_o falls.
- Reset asserted mid-sequence: every FSM returns to HOLD on the next edge with the power-on counter values; sticky flags clear.

## Configuration
- CARFIELD_RST_TIMEOUT_EN defined:
  - In ISOLATE a per-domain counter counts cycles without ack.
  - After TimeoutCycles cycles the FSM enters HOLD anyway (forced reset) and sets timeout_o[i].
  - An ack on the same edge as the timeout takes priority; the flag is not set.
  - timeout_o[i] stays set until timeout_clr_i=1 or reset. If set and clear occur on the same edge, set wins.
- Undefined:
  - ISOLATE waits indefinitely.
  - timeout_o is tied to 0 and timeout_clr_i is unused.
  - No timeout counter is instantiated.

## Structure
- carfield_pkg gains:
  - NumRstDomains (=6).
  - carfield_rst_state_e (IDLE, ISOLATE, HOLD, UNISO; 2-bit).
  - Default HoldCycles and TimeoutCycles constants.
- Sub-module carfield_rst_dom_fsm (one domain: FSM, hold counter, optional timeout counter). Instantiated NumDomains times with the power-on offset passed as a parameter.

## Test plan
- Power-on, defaults: rst_ni low 5 cycles then high -> dom_rst_no[0] rises at cycle 16, dom_rst_no[5] at cycle 21; iso_o[i] falls one cycle after each.
- Request domain 3, ack 4 cycles after iso_o rises -> dom_rst_no[3] low exactly 16 cycles; busy_o[3] high throughout; other domains untouched.
- Requests on domains 1 and 4 in the same cycle with acks 2 cycles apart -> both sequences complete independently, with reset windows offset by 2 cycles.
- Second pulse on rst_req_i[2] during HOLD -> ignored; exactly one 16-cycle reset window.
- With CARFIELD_RST_TIMEOUT_EN, TimeoutCycles=8, no ack -> HOLD entered after 8 cycles and timeout_o[0]=1. The flag persists until timeout_clr_i=1. With the ack arriving on the 8th cycle instead, the flag stays 0.
- rst_ni pulled low during HOLD of domain 5 -> all outputs return to reset values next edge; power-on stagger restarts.

Source files
------------

// File: rtl/carfield_rst_seq_pkg.sv
// Shared types and defaults for the Carfield reset-domain sequencer.
package carfield_rst_seq_pkg;

    localparam int unsigned NumRstDomains           = 6;
    localparam int unsigned DefaultRstHoldCycles    = 16;
    localparam int unsigned DefaultRstTimeoutCycles = 256;

    // Index order of the domain reset vectors.
    typedef enum logic [2:0] {
        RST_DOM_PERIPH     = 3'd0,
        RST_DOM_SAFETY     = 3'd1,
        RST_DOM_SECURITY   = 3'd2,
        RST_DOM_INTCLUSTER = 3'd3,
        RST_DOM_FPCLUSTER  = 3'd4,
        RST_DOM_L2         = 3'd5
    } carfield_rst_dom_e;

    typedef enum logic [1:0] {
        RST_IDLE    = 2'd0,
        RST_ISOLATE = 2'd1,
        RST_HOLD    = 2'd2,
        RST_UNISO   = 2'd3
    } carfield_rst_state_e;

    // Wide enough for the largest power-on load HoldCycles-1+(NumDomains-1).
    function automatic int unsigned rst_cnt_width(input int unsigned hold_cycles,
                                                  input int unsigned num_domains);
        return $clog2(hold_cycles + num_domains) + 1;
    endfunction

endpackage

// File: rtl/carfield_rst_seq_if.sv
// Request/isolation handshake bundle between the register file, the sequencer and the islands.
interface carfield_rst_seq_if #(
    parameter int unsigned NumDomains = carfield_rst_seq_pkg::NumRstDomains
);

    logic [NumDomains-1:0] rst_req_i;
    logic [NumDomains-1:0] iso_ack_i;
    logic                  timeout_clr_i;
    logic [NumDomains-1:0] iso_o;
    logic [NumDomains-1:0] dom_rst_no;
    logic [NumDomains-1:0] busy_o;
    logic [NumDomains-1:0] timeout_o;

    modport master (
        output rst_req_i,
        output iso_ack_i,
        output timeout_clr_i,
        input  iso_o,
        input  dom_rst_no,
        input  busy_o,
        input  timeout_o
    );

    modport slave (
        input  rst_req_i,
        input  iso_ack_i,
        input  timeout_clr_i,
        output iso_o,
        output dom_rst_no,
        output busy_o,
        output timeout_o
    );

endinterface

// File: rtl/carfield_rst_seq_dom_fsm.sv
// Single reset-domain sequencer: isolate, hold reset, de-isolate.
// Optional isolation-ack timeout enabled by CARFIELD_RST_TIMEOUT_EN.
module carfield_rst_dom_fsm
    import carfield_rst_seq_pkg::*;
#(
    parameter int unsigned HoldCycles    = DefaultRstHoldCycles,
    parameter int unsigned TimeoutCycles = DefaultRstTimeoutCycles,
    parameter int unsigned RstOffset     = 0,
    parameter int unsigned CntWidth      = rst_cnt_width(DefaultRstHoldCycles, NumRstDomains)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rst_req_i,
    input  logic iso_ack_i,
    input  logic timeout_clr_i,
    output logic iso_o,
    output logic rst_no,
    output logic busy_o,
    output logic timeout_o
);

    localparam logic [CntWidth-1:0] HoldLoad = CntWidth'(HoldCycles - 1);
    localparam logic [CntWidth-1:0] PorLoad  = CntWidth'(HoldCycles - 1 + RstOffset);

    carfield_rst_state_e state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                timed_out;

`ifdef CARFIELD_RST_TIMEOUT_EN
    localparam int unsigned ToWidth = $clog2(TimeoutCycles + 1);

    logic [ToWidth-1:0] to_cnt_q, to_cnt_d;
    logic               timeout_q, timeout_d;

    // A same-edge ack suppresses the timeout; a same-edge set beats the clear.
    always_comb begin
        to_cnt_d  = '0;
        timed_out = 1'b0;
        if (state_q == RST_ISOLATE && !iso_ack_i) begin
            if (to_cnt_q == ToWidth'(TimeoutCycles - 1)) begin
                timed_out = 1'b1;
                to_cnt_d  = to_cnt_q;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
        timeout_d = timed_out | (timeout_q & ~timeout_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout;

    assign timed_out      = 1'b0;
    assign timeout_o      = 1'b0;
    assign unused_timeout = timeout_clr_i | (TimeoutCycles == 0);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RST_IDLE: begin
                if (rst_req_i) state_d = RST_ISOLATE;
            end
            RST_ISOLATE: begin
                if (iso_ack_i || timed_out) begin
                    state_d = RST_HOLD;
                    cnt_d   = HoldLoad;
                end
            end
            RST_HOLD: begin
                if (cnt_q == '0) state_d = RST_UNISO;
                else             cnt_d   = cnt_q - 1'b1;
            end
            RST_UNISO: begin
                state_d = RST_IDLE;
            end
            default: begin
                state_d = RST_IDLE;
            end
        endcase
    end

    // Reset parks every domain in HOLD with a staggered count, giving the power-on release order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= RST_HOLD;
            cnt_q   <= PorLoad;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign iso_o  = (state_q != RST_IDLE);
    assign rst_no = (state_q != RST_HOLD);
    assign busy_o = (state_q != RST_IDLE);

endmodule

// File: rtl/carfield_rst_seq.sv
// Carfield per-island reset sequencer: one independent domain FSM per reset domain.
// Isolation-ack timeout is enabled by defining CARFIELD_RST_TIMEOUT_EN.
module carfield_rst_seq
    import carfield_rst_seq_pkg::*;
#(
    parameter int unsigned NumDomains    = NumRstDomains,
    parameter int unsigned HoldCycles    = DefaultRstHoldCycles,
    parameter int unsigned TimeoutCycles = DefaultRstTimeoutCycles
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    carfield_rst_seq_if.slave rst_bus
);

    localparam int unsigned CntWidth = rst_cnt_width(HoldCycles, NumDomains);

    logic [NumDomains-1:0] iso;
    logic [NumDomains-1:0] dom_rst_n;
    logic [NumDomains-1:0] busy;
    logic [NumDomains-1:0] timeout;

    for (genvar i = 0; i < NumDomains; i++) begin : gen_dom
        carfield_rst_dom_fsm #(
            .HoldCycles    (HoldCycles),
            .TimeoutCycles (TimeoutCycles),
            .RstOffset     (i),
            .CntWidth      (CntWidth)
        ) u_dom_fsm (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .rst_req_i     (rst_bus.rst_req_i[i]),
            .iso_ack_i     (rst_bus.iso_ack_i[i]),
            .timeout_clr_i (rst_bus.timeout_clr_i),
            .iso_o         (iso[i]),
            .rst_no        (dom_rst_n[i]),
            .busy_o        (busy[i]),
            .timeout_o     (timeout[i])
        );
    end

    assign rst_bus.iso_o      = iso;
    assign rst_bus.dom_rst_no = dom_rst_n;
    assign rst_bus.busy_o     = busy;
    assign rst_bus.timeout_o  = timeout;

endmodule

// File: tb/tb_carfield_rst_seq.sv
// Directed bench for carfield_rst_seq; timeout scenarios run when CARFIELD_RST_TIMEOUT_EN is defined.
module tb_carfield_rst_seq;
    import carfield_rst_seq_pkg::*;

    localparam int unsigned N = NumRstDomains;
    localparam int unsigned H = 16;
`ifdef CARFIELD_RST_TIMEOUT_EN
    localparam int unsigned T = 8;
`else
    localparam int unsigned T = 256;
`endif

    typedef int unsigned dom_arr_t [N];

    logic clk_i = 1'b0;
    logic rst_ni;

    carfield_rst_seq_if #(.NumDomains(N)) rst_bus ();

    carfield_rst_seq #(
        .NumDomains    (N),
        .HoldCycles    (H),
        .TimeoutCycles (T)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .rst_bus (rst_bus)
    );

    always #5 clk_i = ~clk_i;

    int unsigned    n_checks = 0;
    int unsigned    n_pass   = 0;
    logic [N-1:0]   exp_to   = '0;
    dom_arr_t       ra, aa, r2;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string name, input int unsigned k,
                             input logic [N-1:0] e_iso, input logic [N-1:0] e_rst);
        check_eq($sformatf("%s iso k=%0d", name, k),     32'(rst_bus.iso_o),      32'(e_iso));
        check_eq($sformatf("%s rst_n k=%0d", name, k),   32'(rst_bus.dom_rst_no), 32'(e_rst));
        check_eq($sformatf("%s busy k=%0d", name, k),    32'(rst_bus.busy_o),     32'(e_iso));
        check_eq($sformatf("%s timeout k=%0d", name, k), 32'(rst_bus.timeout_o),  32'(exp_to));
    endtask

    // Hold reset, then expect domain d's reset to rise after edge H+d and iso to drop one edge later.
    task automatic power_on(input int unsigned low_cycles);
        logic [N-1:0] e_iso, e_rst;
        @(negedge clk_i);
        rst_ni                = 1'b0;
        rst_bus.rst_req_i     = '0;
        rst_bus.iso_ack_i     = '0;
        rst_bus.timeout_clr_i = 1'b0;
        exp_to                = '0;
        for (int unsigned c = 0; c < low_cycles; c++) begin
            @(posedge clk_i); #1;
            check_all("reset", c, '1, '0);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int unsigned k = 1; k <= H + N + 2; k++) begin
            @(posedge clk_i); #1;
            for (int unsigned d = 0; d < N; d++) begin
                e_rst[d] = (k >= H + d);
                e_iso[d] = (k < H + d + 1);
            end
            check_all("por", k, e_iso, e_rst);
        end
    endtask

    // Edge indices are 1-based; 0 means none. A missing ack means the timeout at req+T.
    task automatic run_scn(input string name, input dom_arr_t req_e, input dom_arr_t ack_e,
                           input dom_arr_t req2_e, input int unsigned len);
        logic [N-1:0] e_iso, e_rst;
        int unsigned  ae;
        for (int unsigned k = 1; k <= len; k++) begin
            @(negedge clk_i);
            for (int unsigned d = 0; d < N; d++) begin
                rst_bus.rst_req_i[d] = (req_e[d] != 0 && req_e[d] == k) ||
                                       (req2_e[d] != 0 && req2_e[d] == k);
                rst_bus.iso_ack_i[d] = (ack_e[d] != 0 && ack_e[d] == k);
            end
            @(posedge clk_i); #1;
            for (int unsigned d = 0; d < N; d++) begin
                ae = (ack_e[d] != 0) ? ack_e[d] : req_e[d] + T;
                e_iso[d] = (req_e[d] != 0) && (k >= req_e[d]) && (k <= ae + H);
                e_rst[d] = !((req_e[d] != 0) && (k >= ae) && (k <= ae + H - 1));
                if (req_e[d] != 0 && ack_e[d] == 0 && k == ae) exp_to[d] = 1'b1;
            end
            check_all(name, k, e_iso, e_rst);
        end
        @(negedge clk_i);
        rst_bus.rst_req_i = '0;
        rst_bus.iso_ack_i = '0;
    endtask

    task automatic pulse_clr();
        @(negedge clk_i);
        rst_bus.timeout_clr_i = 1'b1;
        @(posedge clk_i); #1;
        exp_to = '0;
        check_eq("timeout_clr", 32'(rst_bus.timeout_o), 32'(exp_to));
        @(negedge clk_i);
        rst_bus.timeout_clr_i = 1'b0;
    endtask

    initial begin
        rst_ni                = 1'b0;
        rst_bus.rst_req_i     = '0;
        rst_bus.iso_ack_i     = '0;
        rst_bus.timeout_clr_i = 1'b0;

        power_on(5);

        // Domain 3: ack four cycles after isolation rises.
        ra = '{0, 0, 0, 1, 0, 0}; aa = '{0, 0, 0, 5, 0, 0}; r2 = '{0, 0, 0, 0, 0, 0};
        run_scn("dom3", ra, aa, r2, 24);

        // Domains 1 and 4 together, acks two cycles apart.
        ra = '{0, 1, 0, 0, 1, 0}; aa = '{0, 3, 0, 0, 5, 0}; r2 = '{0, 0, 0, 0, 0, 0};
        run_scn("dom1_4", ra, aa, r2, 24);

        // Domain 2: second request pulse during HOLD must be ignored.
        ra = '{0, 0, 1, 0, 0, 0}; aa = '{0, 0, 2, 0, 0, 0}; r2 = '{0, 0, 8, 0, 0, 0};
        run_scn("dom2_req2", ra, aa, r2, 22);

        pulse_clr();

`ifdef CARFIELD_RST_TIMEOUT_EN
        // Domain 0 without ack: forced HOLD after T cycles, sticky flag until cleared.
        ra = '{1, 0, 0, 0, 0, 0}; aa = '{0, 0, 0, 0, 0, 0}; r2 = '{0, 0, 0, 0, 0, 0};
        run_scn("dom0_to", ra, aa, r2, T + H + 4);
        pulse_clr();

        // Ack on the same edge the timeout would fire: no flag.
        ra = '{1, 0, 0, 0, 0, 0}; aa = '{T + 1, 0, 0, 0, 0, 0}; r2 = '{0, 0, 0, 0, 0, 0};
        run_scn("dom0_ack_at_to", ra, aa, r2, T + H + 4);
`endif

        // Domain 5 in HOLD when reset hits: everything back to reset state, stagger restarts.
        ra = '{0, 0, 0, 0, 0, 1}; aa = '{0, 0, 0, 0, 0, 2}; r2 = '{0, 0, 0, 0, 0, 0};
        run_scn("dom5_pre_rst", ra, aa, r2, 6);
        power_on(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
